// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light controller and its monitor.
// Dwell defaults are in 0.5 s clocks.
package traffic_light_pkg;

   typedef enum logic [2:0] {
      PH_P0 = 3'b100,
      PH_P1 = 3'b010,
      PH_P2 = 3'b001
   } ph_code_e;

   typedef enum logic [1:0] {
      IX_P0   = 2'd0,
      IX_P1   = 2'd1,
      IX_P2   = 2'd2,
      IX_NONE = 2'd3
   } ph_idx_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      TRACK = 2'd2
   } mon_state_e;

   localparam int FLT_CODE  = 0;
   localparam int FLT_ORDER = 1;
   localparam int FLT_DWELL = 2;

   localparam int P0_CYC_DEF = 61;
   localparam int P1_CYC_DEF = 7;
   localparam int P2_CYC_DEF = 5;

endpackage

// File: rtl/traffic_phase_decode.sv
// Combinational leds decoder: legality, phase index and successor index.
// Anything other than an exact one-hot code (including X) is invalid.
module traffic_phase_decode
   import traffic_light_pkg::*;
(
   input  logic [2:0] leds,
   output logic       valid,
   output ph_idx_e    idx,
   output ph_idx_e    nxt
);

   always_comb begin
      valid = 1'b1;
      idx   = IX_NONE;
      nxt   = IX_NONE;
      unique case (leds)
         PH_P0: begin
            idx = IX_P0;
            nxt = IX_P1;
         end
         PH_P1: begin
            idx = IX_P1;
            nxt = IX_P2;
         end
         PH_P2: begin
            idx = IX_P2;
            nxt = IX_P0;
         end
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of the controller leds bus: code, phase order and dwell.
// Define TRAFFIC_MON_CYCLE_CNT_EN to add the clean-round counter `cycles`.
module traffic_light_monitor
   import traffic_light_pkg::*;
#(
   parameter int P0_CYC = P0_CYC_DEF,
   parameter int P1_CYC = P1_CYC_DEF,
   parameter int P2_CYC = P2_CYC_DEF,
   parameter int TOL    = 0,
   parameter int CW     = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [2:0]    leds,
   input  logic          fault_clr,
   output logic [1:0]    phase,
   output logic          locked,
   output logic [CW-1:0] dwell,
   output logic [2:0]    fault,
   output logic          fault_pulse
`ifdef TRAFFIC_MON_CYCLE_CNT_EN
   ,
   output logic [15:0]   cycles
`endif
);

   localparam logic [CW-1:0] DW_MAX = '1;

   mon_state_e    state_q, state_d;
   ph_idx_e       ph_q, ph_d;
   ph_idx_e       exp_q, exp_d;
   logic          locked_d;
   logic [CW-1:0] dwell_d, dwell_inc;
   logic [2:0]    fault_d, ev;
   logic          v;
   ph_idx_e       ix, ix_nxt;
   int            p_cyc;

   traffic_phase_decode u_dec (
      .leds  (leds),
      .valid (v),
      .idx   (ix),
      .nxt   (ix_nxt)
   );

   assign phase = ph_q;

   always_comb begin
      unique case (ph_q)
         IX_P0:   p_cyc = P0_CYC;
         IX_P1:   p_cyc = P1_CYC;
         default: p_cyc = P2_CYC;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      ph_d      = ph_q;
      exp_d     = exp_q;
      locked_d  = locked;
      dwell_d   = dwell;
      ev        = '0;
      dwell_inc = (dwell == DW_MAX) ? dwell : dwell + CW'(1);
      unique case (state_q)
         IDLE: begin
            if (v) begin
               state_d = SYNC;
               ph_d    = ix;
               exp_d   = ix_nxt;
               dwell_d = CW'(1);
            end
         end
         default: begin
            if (!v) begin
               ev[FLT_CODE] = 1'b1;
               state_d  = IDLE;
               ph_d     = IX_NONE;
               exp_d    = IX_NONE;
               locked_d = 1'b0;
               dwell_d  = '0;
            end else if (ix == ph_q) begin
               dwell_d = dwell_inc;
               // edge on the limit, so saturation cannot re-flag
               if (state_q == TRACK &&
                   int'(dwell_inc) == p_cyc + TOL + 1 &&
                   dwell != dwell_inc)
                  ev[FLT_DWELL] = 1'b1;
            end else if (ix == exp_q) begin
               if (state_q == TRACK &&
                   int'(dwell) < p_cyc - TOL)
                  ev[FLT_DWELL] = 1'b1;
               state_d  = TRACK;
               locked_d = 1'b1;
               ph_d     = ix;
               exp_d    = ix_nxt;
               dwell_d  = CW'(1);
            end else begin
               ev[FLT_ORDER] = 1'b1;
               state_d  = SYNC;
               locked_d = 1'b0;
               ph_d     = ix;
               exp_d    = ix_nxt;
               dwell_d  = CW'(1);
            end
         end
      endcase
      fault_d = (fault_clr ? 3'b000 : fault) | ev;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         ph_q        <= IX_NONE;
         exp_q       <= IX_NONE;
         locked      <= 1'b0;
         dwell       <= '0;
         fault       <= '0;
         fault_pulse <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_q        <= ph_d;
         exp_q       <= exp_d;
         locked      <= locked_d;
         dwell       <= dwell_d;
         fault       <= fault_d;
         fault_pulse <= |ev;
      end
   end

`ifdef TRAFFIC_MON_CYCLE_CNT_EN
   logic [15:0] cyc_q, cyc_d;
   logic        clean_q, clean_d;

   assign cycles = cyc_q;

   // a round counts only if it started on a locked entry into P0
   always_comb begin
      cyc_d   = cyc_q;
      clean_d = clean_q;
      if (|ev || !locked_d) begin
         cyc_d   = '0;
         clean_d = 1'b0;
      end else if (ph_d == IX_P0 && ph_q != IX_P0) begin
         if (state_q == TRACK && clean_q &&
             cyc_q != 16'hFFFF)
            cyc_d = cyc_q + 16'd1;
         clean_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cyc_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         cyc_q   <= cyc_d;
         clean_q <= clean_d;
      end
   end
`endif

endmodule
